// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM meter: counter width, counter limits and
// the measurement state encoding.
package pwm_pkg;

  localparam int CNT_W = 16;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } meter_state_t;

endpackage

// File: rtl/pwm_edge_det.sv
// Edge detector: remembers the previous sample of d and flags rising and
// falling transitions seen at the current clock edge.
module pwm_edge_det
  import pwm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic prev;

  // One-cycle history of the input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 1'b0;
    end else begin
      prev <= d;
    end
  end

  assign rise = d & ~prev;
  assign fall = ~d & prev;

endmodule

// File: rtl/pwm_meter.sv
// PWM meter: measures period and high time between consecutive rising edges
// of pwm_in, publishing each completed period with a one-cycle valid pulse.
// A period longer than the counter range raises a sticky ovf flag and the
// meter re-arms without publishing.
module pwm_meter
  import pwm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             ovf,
  output logic             busy
);

  meter_state_t     state, state_nxt;
  logic [CNT_W-1:0] pcnt, pcnt_nxt;
  logic [CNT_W-1:0] hcnt, hcnt_nxt;
  logic [CNT_W-1:0] period_nxt, high_nxt;
  logic             valid_nxt, ovf_nxt;
  logic             rise, fall;

  // Increment that holds at full scale; the overflow check normally fires
  // first, this only guarantees the counters can never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  pwm_edge_det u_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (pwm_in),
    .rise (rise),
    .fall (fall)
  );

  // State, counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pcnt      <= CNT_ZERO;
      hcnt      <= CNT_ZERO;
      period    <= CNT_ZERO;
      high_time <= CNT_ZERO;
      valid     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_nxt;
      pcnt      <= pcnt_nxt;
      hcnt      <= hcnt_nxt;
      period    <= period_nxt;
      high_time <= high_nxt;
      valid     <= valid_nxt;
      ovf       <= ovf_nxt;
    end
  end

  // Next-state, counting, publish and overflow decisions.
  always_comb begin
    state_nxt  = state;
    pcnt_nxt   = pcnt;
    hcnt_nxt   = hcnt;
    period_nxt = period;
    high_nxt   = high_time;
    valid_nxt  = 1'b0;
    ovf_nxt    = ovf;

    if (!en) begin
      // Disable dominates everything, including a coincident rise.
      state_nxt = IDLE;
      pcnt_nxt  = CNT_ZERO;
      hcnt_nxt  = CNT_ZERO;
      ovf_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = ARM;
          pcnt_nxt  = CNT_ZERO;
          hcnt_nxt  = CNT_ZERO;
        end
        ARM: begin
          // The partial period before the first rise is discarded.
          if (rise) begin
            state_nxt = HIGH;
            pcnt_nxt  = CNT_ONE;
            hcnt_nxt  = CNT_ONE;
          end
        end
        HIGH: begin
          if (pcnt == CNT_MAX) begin
            state_nxt = ARM;
            ovf_nxt   = 1'b1;
            pcnt_nxt  = CNT_ZERO;
            hcnt_nxt  = CNT_ZERO;
          end else begin
            pcnt_nxt = sat_inc(pcnt);
            if (pwm_in) begin
              hcnt_nxt = sat_inc(hcnt);
            end
            if (fall) begin
              state_nxt = LOW;
            end
          end
        end
        LOW: begin
          if (rise) begin
            // The rising cycle is the first high cycle of the next period.
            period_nxt = pcnt;
            high_nxt   = hcnt;
            valid_nxt  = 1'b1;
            pcnt_nxt   = CNT_ONE;
            hcnt_nxt   = CNT_ONE;
            state_nxt  = HIGH;
          end else if (pcnt == CNT_MAX) begin
            state_nxt = ARM;
            ovf_nxt   = 1'b1;
            pcnt_nxt  = CNT_ZERO;
            hcnt_nxt  = CNT_ZERO;
          end else begin
            pcnt_nxt = sat_inc(pcnt);
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_pwm_meter.sv
// Testbench for pwm_meter: directed PWM waveforms, expected results pushed
// to a scoreboard queue when each rising edge is driven, and a monitor that
// pops and compares every valid pulse (values and arrival cycle).
module tb_pwm_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        pwm_in;
  logic [15:0] period;
  logic [15:0] high_time;
  logic        valid;
  logic        ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int p;
    int h;
    int c;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pwm_meter dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pwm_in    (pwm_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every valid pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst === 1'b0 && valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_valid", {31'd0, valid}, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("period", {16'd0, period}, mon_e.p);
        chk("high_time", {16'd0, high_time}, mon_e.h);
        chk("valid_cycle", cyc, mon_e.c);
      end
    end
  end

  task automatic drive(input logic b);
    @(negedge clk);
    pwm_in = b;
  endtask

  // Rise driven now is sampled at the next posedge; valid is seen one
  // negedge later, when cyc has advanced by one.
  task automatic push_exp(input int p, input int h);
    sbq.push_back('{p, h, cyc + 1});
  endtask

  // n periods of a counter PWM (cnt 0..top, high while cnt < cmp).
  // The first rise publishes (fp,fh) only if the meter is already in LOW.
  task automatic pwm_run(input int top, input int cmp, input int n,
                         input bit pub_first, input int fp, input int fh,
                         input int ep, input int eh);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j <= top; j++) begin
        drive(j < cmp);
        if (j == 0 && cmp > 0) begin
          if (i > 0) push_exp(ep, eh);
          else if (pub_first) push_exp(fp, fh);
        end
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_period", {16'd0, period}, 0);
    chk("rst_high_time", {16'd0, high_time}, 0);
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    chk("rst_busy", {31'd0, busy}, 0);

    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 0);
    en = 1'b1;
    @(negedge clk);
    chk("arm_busy", {31'd0, busy}, 1);

    // top=4 cmp=2: period 5 high 2 from the second rise onward
    pwm_run(4, 2, 4, 1'b0, 0, 0, 5, 2);
    // top=9 cmp=1: single-cycle pulse, period 10 high 1
    pwm_run(9, 1, 3, 1'b1, 5, 2, 10, 1);

    // cmp=10: constant high; the rise closes the last 10/1 period
    drive(1'b1);
    push_exp(10, 1);
    repeat (65535) @(negedge clk);
    chk("ovf_not_yet", {31'd0, ovf}, 0);
    @(negedge clk);
    chk("ovf_const_high", {31'd0, ovf}, 1);
    chk("ovf_busy_arm", {31'd0, busy}, 1);
    chk("ovf_period_held", {16'd0, period}, 10);
    chk("ovf_high_held", {16'd0, high_time}, 1);
    repeat (10) @(negedge clk);

    // ovf stays set across later valid pulses
    repeat (3) drive(1'b0);
    pwm_run(4, 2, 3, 1'b0, 0, 0, 5, 2);
    @(negedge clk);
    chk("ovf_sticky", {31'd0, ovf}, 1);

    // en low clears ovf and returns to IDLE, results held
    en = 1'b0;
    @(negedge clk);
    chk("dis_busy", {31'd0, busy}, 0);
    chk("dis_ovf", {31'd0, ovf}, 0);
    chk("dis_period_held", {16'd0, period}, 5);
    en = 1'b1;

    // cmp=0: constant low, meter waits in ARM without overflow
    repeat (40) drive(1'b0);
    chk("low_busy", {31'd0, busy}, 1);
    chk("low_ovf", {31'd0, ovf}, 0);

    // en dropped for one cycle exactly at a rise: no publish
    pwm_run(4, 2, 2, 1'b0, 0, 0, 5, 2);
    @(negedge clk);
    pwm_in = 1'b1;
    en     = 1'b0;
    @(negedge clk);
    en = 1'b1;
    chk("drop_busy", {31'd0, busy}, 0);
    chk("drop_ovf", {31'd0, ovf}, 0);
    drive(1'b0);
    drive(1'b0);
    drive(1'b0);
    pwm_run(4, 2, 2, 1'b0, 0, 0, 5, 2);

    // Asynchronous reset while in LOW with 5/2 published
    pwm_run(4, 2, 2, 1'b1, 5, 2, 5, 2);
    @(negedge clk);
    pwm_in = 1'b0;
    chk("pre_rst_period", {16'd0, period}, 5);
    #2 rst = 1'b1;
    #1;
    chk("arst_period", {16'd0, period}, 0);
    chk("arst_high_time", {16'd0, high_time}, 0);
    chk("arst_valid", {31'd0, valid}, 0);
    chk("arst_ovf", {31'd0, ovf}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    pwm_run(4, 2, 2, 1'b0, 0, 0, 5, 2);

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
